if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch control plus IF/ID pipeline register, directly downstream of the PC register.
- Issues one instruction-memory request per PC value and computes the next PC (sequential or branch redirect).
- Drives the PC register's write enable, which is its hazard-hold input.
- Presents the fetched instruction and PC+4 to the ID stage, with stall, flush and a one-entry hold buffer.

Parameters:
- XLEN, 32, datapath and address width.
- PC_STEP, 4, byte increment for sequential fetch.
- NOP_INSTR, 32'h0000_0000, instruction word presented while the IF/ID register is invalid.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  begin fetching; sampled only in IDLE.
- pc_i  in  XLEN  current PC from the PC register.
- hazard_stall_i  in  1  load-use stall from hazard detection; hold IF/ID.
- flush_i  in  1  branch taken in ID; squash IF/ID and redirect.
- branch_target_i  in  XLEN  redirect target, valid when flush_i=1.
- imem_req_o  out  1  instruction-memory request.
- imem_addr_o  out  XLEN  request address (= pc_i).
- imem_ack_i  in  1  read data valid this cycle.
- imem_data_i  in  XLEN  instruction word.
- pc_next_o  out  XLEN  next PC value to the PC register.
- pc_write_o  out  1  PC register write enable.
- instr_o  out  XLEN  IF/ID instruction.
- pc_plus4_o  out  XLEN  IF/ID PC+PC_STEP.
- valid_o  out  1  IF/ID contents valid.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; valid_o=0; instr_o=NOP_INSTR; pc_plus4_o=0.
  - hold buffer empty; redirect_pending=0.
  - Combinational outputs imem_req_o=0 and pc_write_o=0 while in IDLE.
- imem_req_o, imem_addr_o, pc_next_o and pc_write_o are combinational from state and inputs. All other outputs are registered.
- pc_next_o defaults to pc_i+PC_STEP (mod 2^XLEN, wraps silently). It is branch_target_i or the redirect register when redirecting.
- IDLE:
  - No request, pc_write_o=0.
  - start_i=1 -> FETCH.
  - flush_i and hazard_stall_i are ignored.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc_i. pc_i is stable because pc_write_o=0 until ack.
  - Exactly one outstanding request.
  - Ack with (flush_i | redirect_pending): data discarded; pc_write_o=1; pc_next_o=(flush_i ? branch_target_i : redirect_target); valid_o<=0; redirect_pending<=0; stay FETCH.
  - Ack with hazard_stall_i=1: {imem_data_i, pc_i+PC_STEP} -> hold buffer; pc_write_o=1; IF/ID unchanged; -> HELD.
  - Ack, otherwise: IF/ID <= {imem_data_i, pc_i+PC_STEP, valid=1}; pc_write_o=1; stay FETCH. Latency: ack in cycle N -> valid_o=1 in N+1.
  - No ack with flush_i: redirect_pending<=1; redirect_target<=branch_target_i; valid_o<=0; pc_write_o=0. A later flush overwrites the target.
  - No ack with hazard_stall_i (no flush): IF/ID held.
  - No ack, neither: valid_o<=0 (bubble); instr_o<=NOP_INSTR.
- HELD:
  - imem_req_o=0.
  - flush_i=1: hold discarded; valid_o<=0; pc_write_o=1; pc_next_o=branch_target_i; -> FETCH.
  - Else hazard_stall_i=0: IF/ID <= hold buffer (valid=1); pc_write_o=0; -> FETCH.
  - Else stay; pc_write_o=0.
- Priority: flush over stall in every state.
- Once IDLE is left, start_i is ignored until reset.
- Reset mid-request: in-flight ack is ignored. Memory must tolerate an abandoned request.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, HELD as 2-bit typedef) and the NOP_INSTR constant.
- One sub-module: if_id_reg. It holds instr/pc_plus4/valid with load, hold and flush controls, and has the same async reset.

Test Plan:
- Reset, start_i=1, pc_i=0x100, ack on 2nd FETCH cycle with data 0xDEADBEEF -> next cycle valid_o=1, instr_o=0xDEADBEEF, pc_plus4_o=0x104; pc_write_o=1, pc_next_o=0x104 on the ack cycle.
- Ack coincident with hazard_stall_i=1 for 3 cycles -> state HELD, imem_req_o=0, IF/ID unchanged. The held word appears on the cycle after the stall drops; PC written once only.
- flush_i=1, branch_target_i=0x200 while awaiting ack -> valid_o=0. Later ack data discarded; pc_next_o=0x200 with pc_write_o=1 on the ack cycle.
- flush_i and hazard_stall_i both high in HELD -> hold dropped, pc_next_o=branch_target_i, valid_o=0, -> FETCH.
- pc_i=0xFFFF_FFFC, ack -> pc_next_o=0x0000_0000, pc_plus4_o=0x0.
- rst_i asserted mid-FETCH and mid-HELD -> outputs at reset values immediately. imem_req_o stays 0 until start_i.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the instruction-fetch control and IF/ID pipeline register.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HELD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: load, clear (squash/bubble) or hold, with async reset.
module if_id_reg #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  // Clear wins over load so a squash can never be overridden by a late fill.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (clear_i) begin
      instr_d = NOP_INSTR[XLEN-1:0];
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q    <= NOP_INSTR[XLEN-1:0];
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch control with PC-write handshake, redirect tracking and a
// one-entry hold buffer in front of the IF/ID register.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            hazard_stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_write_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc4_q, hold_pc4_d;
  logic            redir_pend_q, redir_pend_d;
  logic [XLEN-1:0] redir_tgt_q, redir_tgt_d;

  logic [XLEN-1:0] pc_plus_step;
  logic            ifid_load, ifid_clear;
  logic [XLEN-1:0] ifid_instr, ifid_pc4;

  assign pc_plus_step = pc_i + STEP;
  assign imem_req_o   = (state_q == ST_FETCH);
  assign imem_addr_o  = pc_i;

  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    pc_next_o    = pc_plus_step;
    pc_write_o   = 1'b0;
    ifid_load    = 1'b0;
    ifid_clear   = 1'b0;
    ifid_instr   = imem_data_i;
    ifid_pc4     = pc_plus_step;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_ack_i) begin
          // PC advances exactly once per returned word, whatever happens to it.
          pc_write_o = 1'b1;
          if (flush_i || redir_pend_q) begin
            pc_next_o    = flush_i ? branch_target_i : redir_tgt_q;
            ifid_clear   = 1'b1;
            redir_pend_d = 1'b0;
          end else if (hazard_stall_i) begin
            hold_instr_d = imem_data_i;
            hold_pc4_d   = pc_plus_step;
            state_d      = ST_HELD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (flush_i) begin
          // The request in flight is for a wrong-path PC; remember where to go.
          redir_pend_d = 1'b1;
          redir_tgt_d  = branch_target_i;
          ifid_clear   = 1'b1;
        end else if (!hazard_stall_i) begin
          ifid_clear = 1'b1;
        end
      end

      ST_HELD: begin
        if (flush_i) begin
          pc_write_o = 1'b1;
          pc_next_o  = branch_target_i;
          ifid_clear = 1'b1;
          state_d    = ST_FETCH;
        end else if (!hazard_stall_i) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_instr_q;
          ifid_pc4   = hold_pc4_q;
          state_d    = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      hold_instr_q <= NOP_INSTR[XLEN-1:0];
      hold_pc4_q   <= '0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ifid_load),
    .clear_i    (ifid_clear),
    .instr_i    (ifid_instr),
    .pc_plus4_i (ifid_pc4),
    .instr_o    (instr_o),
    .pc_plus4_o (pc_plus4_o),
    .valid_o    (valid_o)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Randomised and directed bench for if_id_stage against a cycle-level fetch model.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        hazard_stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic [31:0] pc_next_o;
  logic        pc_write_o;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  int total = 0;
  int bad = 0;

  if_id_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .pc_i            (pc_i),
    .hazard_stall_i  (hazard_stall_i),
    .flush_i         (flush_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .pc_next_o       (pc_next_o),
    .pc_write_o      (pc_write_o),
    .instr_o         (instr_o),
    .pc_plus4_o      (pc_plus4_o),
    .valid_o         (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: where fetching stands, the parked word, the pending redirect
  // and the expected IF/ID contents; the bench also plays the PC register.
  typedef enum int {M_IDLE, M_FETCH, M_HELD} mode_t;
  mode_t       mode;
  bit          pend;
  logic [31:0] ptgt, park_instr, park_pc4;
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;
  logic [31:0] pc_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [31:0] pc0);
    mode = M_IDLE; pend = 0; ptgt = '0;
    park_instr = NOP; park_pc4 = '0;
    m_instr = NOP; m_pc4 = '0; m_valid = 0;
    pc_model = pc0;
  endtask

  // Asserted away from a clock edge; reset values must appear without a clock.
  task automatic do_reset(input logic [31:0] pc0);
    rst_i = 1'b1;
    start_i = 0; hazard_stall_i = 0; flush_i = 0; imem_ack_i = 0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc4", pc_plus4_o, 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_pcwr", 32'(pc_write_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset(pc0);
    pc_i = pc0;
  endtask

  // One clock: drive, check combinational outputs, advance model, check IF/ID.
  task automatic cyc(input bit st, input bit stl, input bit fl, input logic [31:0] bt,
                     input bit ack, input logic [31:0] dat);
    logic [31:0] e_next, step;
    bit e_wr, e_req;
    start_i = st; hazard_stall_i = stl; flush_i = fl; branch_target_i = bt;
    imem_ack_i = ack; imem_data_i = dat; pc_i = pc_model;
    #2;
    step = pc_model + 32'd4;
    e_req = (mode == M_FETCH);
    e_wr = 0;
    e_next = step;
    if (mode == M_FETCH && ack) begin
      e_wr = 1;
      if (fl) e_next = bt;
      else if (pend) e_next = ptgt;
    end else if (mode == M_HELD && fl) begin
      e_wr = 1;
      e_next = bt;
    end
    chk("imem_req", 32'(imem_req_o), 32'(e_req));
    chk("imem_addr", imem_addr_o, pc_model);
    chk("pc_write", 32'(pc_write_o), 32'(e_wr));
    chk("pc_next", pc_next_o, e_next);

    case (mode)
      M_IDLE: if (st) mode = M_FETCH;
      M_FETCH: begin
        if (ack) begin
          if (fl || pend) begin m_valid = 0; m_instr = NOP; pend = 0; end
          else if (stl) begin park_instr = dat; park_pc4 = step; mode = M_HELD; end
          else begin m_instr = dat; m_pc4 = step; m_valid = 1; end
        end else if (fl) begin
          pend = 1; ptgt = bt; m_valid = 0; m_instr = NOP;
        end else if (!stl) begin
          m_valid = 0; m_instr = NOP;
        end
      end
      M_HELD: begin
        if (fl) begin m_valid = 0; m_instr = NOP; mode = M_FETCH; end
        else if (!stl) begin m_instr = park_instr; m_pc4 = park_pc4; m_valid = 1; mode = M_FETCH; end
      end
      default: ;
    endcase
    if (e_wr) pc_model = e_next;

    @(posedge clk_i); #1;
    chk("valid", 32'(valid_o), 32'(m_valid));
    chk("instr", instr_o, m_instr);
    chk("pc_plus4", pc_plus4_o, m_pc4);
  endtask

  initial begin
    model_reset(32'h100);
    @(posedge clk_i); #1;
    do_reset(32'h100);

    // Basic fetch: ack on the second FETCH cycle.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t1_instr", instr_o, 32'hDEAD_BEEF);
    chk("t1_pc4", pc_plus4_o, 32'h104);
    chk("t1_valid", 32'(valid_o), 32'd1);

    // Ack during a 3-cycle stall parks the word; it lands after the stall drops.
    cyc(0, 1, 0, 0, 1, 32'h1111_1111);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t2_noreq", 32'(imem_req_o), 32'd0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t2_hold_instr", instr_o, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t2_held_word", instr_o, 32'h1111_1111);
    chk("t2_pc_once", pc_model, 32'h108);

    // Flush while waiting: the late ack is discarded and PC redirects.
    cyc(0, 0, 1, 32'h200, 0, 0);
    chk("t3_valid0", 32'(valid_o), 32'd0);
    cyc(0, 0, 0, 32'h0, 0, 0);
    cyc(0, 0, 0, 32'h0, 1, 32'hBAD0_BAD0);
    chk("t3_redirect", pc_model, 32'h200);
    chk("t3_discard", instr_o, NOP);

    // Flush together with stall while HELD.
    cyc(0, 1, 0, 0, 1, 32'h2222_2222);
    cyc(0, 1, 1, 32'h300, 0, 0);
    chk("t4_pc", pc_model, 32'h300);
    chk("t4_valid0", 32'(valid_o), 32'd0);
    chk("t4_req", 32'(imem_req_o), 32'd1);

    // Mid-FETCH reset, then PC wrap-around at the top of the address space.
    do_reset(32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 32'h5555_5555);
    chk("t6_idle_noreq", 32'(imem_req_o), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h3333_3333);
    chk("t5_wrap_pc", pc_model, 32'h0);
    chk("t5_wrap_pc4", pc_plus4_o, 32'h0);

    // Mid-HELD reset.
    cyc(0, 1, 0, 0, 1, 32'h4444_4444);
    do_reset(32'h40);
    cyc(0, 0, 0, 0, 0, 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset({$urandom_range(0, 32'h3FFF), 2'b00});
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, {$urandom(), 2'b00} >> 0,
            $urandom_range(0, 9) < 4, $urandom());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
